// File: rtl/plab4_net_router_switch_alloc_pkg.sv
// Shared definitions for the ring router switch allocator.
// Output index constants match the route encodings produced by route compute.
// Request/grant vectors: bit PORT_PREV = out prev, bit PORT_TERM = out term,
// bit PORT_NEXT = out next. Inside an arbiter the same 3-bit shape is indexed
// by input number instead.
package plab4_net_router_switch_alloc_pkg;

    localparam int NUM_PORTS = 3;

    localparam int PORT_PREV = 0;
    localparam int PORT_TERM = 1;
    localparam int PORT_NEXT = 2;

    typedef logic [NUM_PORTS-1:0] port_vec_t;
    typedef logic [1:0]           port_idx_t;

    // Advance a port index by one, wrapping 2 -> 0.
    function automatic port_idx_t port_idx_inc(input port_idx_t idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/plab4_net_rr_arb3.sv
// Three-input round-robin arbiter with a registered priority pointer.
// The pointer moves to one past the winner; a flush forces no grant this
// cycle and returns the pointer to input 0.
module plab4_net_rr_arb3
    import plab4_net_router_switch_alloc_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  port_vec_t reqs,
    input  logic      flush,
    output port_vec_t grant
);

    port_idx_t ptr_q;
    port_idx_t ptr_d;
    port_idx_t ptr_p1;
    port_idx_t ptr_p2;

    // Pick the first requester at or after the pointer and compute the new pointer.
    always_comb begin
        grant  = '0;
        ptr_d  = ptr_q;
        ptr_p1 = port_idx_inc(ptr_q);
        ptr_p2 = port_idx_inc(ptr_p1);
        if (flush) begin
            ptr_d = 2'd0;
        end else if (reqs[ptr_q]) begin
            grant[ptr_q] = 1'b1;
            ptr_d        = ptr_p1;
        end else if (reqs[ptr_p1]) begin
            grant[ptr_p1] = 1'b1;
            ptr_d         = ptr_p2;
        end else if (reqs[ptr_p2]) begin
            grant[ptr_p2] = 1'b1;
            ptr_d         = ptr_q;   // one past ptr_p2 wraps back to ptr_q
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ptr_q <= 2'd0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/plab4_net_router_switch_alloc.sv
// Switch allocator and ring credit tracker for one router.
// One round-robin arbiter per output; prev/next are masked when their
// downstream credit count is zero, term is masked when the terminal is busy.
// Optional build macro PLAB4_NET_SWITCH_ALLOC_SD_FLUSH_EN: on any change of
// cur_sd, all grants are suppressed for that cycle and every arbiter pointer
// returns to input 0, so arbitration history cannot leak across domains.
module plab4_net_router_switch_alloc
    import plab4_net_router_switch_alloc_pkg::*;
#(
    parameter int p_num_free_nbits = 2,
    parameter int p_credit_init    = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [2:0]                  reqs_in0,
    input  logic [2:0]                  reqs_in1,
    input  logic [2:0]                  reqs_in2,
    output logic [2:0]                  grants_in0,
    output logic [2:0]                  grants_in1,
    output logic [2:0]                  grants_in2,
    input  logic                        term_out_rdy,
    input  logic                        credit_ret_east,
    input  logic                        credit_ret_west,
    output logic [p_num_free_nbits-1:0] num_free_east,
    output logic [p_num_free_nbits-1:0] num_free_west,
    output logic                        credit_err,
    input  logic                        cur_sd
);

    localparam logic [p_num_free_nbits-1:0] CREDIT_MAX = p_num_free_nbits'(p_credit_init);

    logic [p_num_free_nbits-1:0] credit_east_q, credit_east_d;
    logic [p_num_free_nbits-1:0] credit_west_q, credit_west_d;
    logic                        credit_err_q,  credit_err_d;
    logic                        sd_flush;

    // [input][output] and [output][input] views of requests and grants
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] in_reqs;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] in_grants;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] out_reqs;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] out_grants;
    logic [NUM_PORTS-1:0]                out_avail;

    assign in_reqs[0] = reqs_in0;
    assign in_reqs[1] = reqs_in1;
    assign in_reqs[2] = reqs_in2;

    assign grants_in0 = in_grants[0];
    assign grants_in1 = in_grants[1];
    assign grants_in2 = in_grants[2];

    assign out_avail[PORT_PREV] = (credit_east_q != '0);
    assign out_avail[PORT_TERM] = term_out_rdy;
    assign out_avail[PORT_NEXT] = (credit_west_q != '0);

`ifdef PLAB4_NET_SWITCH_ALLOC_SD_FLUSH_EN
    logic prev_sd_q, prev_sd_d;

    // Remember last cycle's domain to detect a switch.
    always_comb begin
        prev_sd_d = cur_sd;
    end

    // Domain history register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prev_sd_q <= 1'b0;
        else        prev_sd_q <= prev_sd_d;
    end

    assign sd_flush = (cur_sd != prev_sd_q);
`else
    logic unused_cur_sd;
    assign unused_cur_sd = cur_sd;
    assign sd_flush      = 1'b0;
`endif

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_out
            for (gj = 0; gj < NUM_PORTS; gj++) begin : g_in
                assign out_reqs[gi][gj]  = in_reqs[gj][gi] & out_avail[gi];
                assign in_grants[gj][gi] = out_grants[gi][gj];
            end
            plab4_net_rr_arb3 u_arb (
                .clk   (clk),
                .reset (reset),
                .reqs  (out_reqs[gi]),
                .flush (sd_flush),
                .grant (out_grants[gi])
            );
        end
    endgenerate

    // Credit bookkeeping: a grant consumes a slot, a return frees one,
    // both together cancel; out-of-range moves saturate and latch the error.
    always_comb begin
        credit_east_d = credit_east_q;
        credit_west_d = credit_west_q;
        credit_err_d  = credit_err_q;

        if ((|out_grants[PORT_PREV]) && !credit_ret_east) begin
            if (credit_east_q == '0) credit_err_d  = 1'b1;
            else                     credit_east_d = credit_east_q - 1'b1;
        end else if (credit_ret_east && !(|out_grants[PORT_PREV])) begin
            if (credit_east_q == CREDIT_MAX) credit_err_d  = 1'b1;
            else                             credit_east_d = credit_east_q + 1'b1;
        end

        if ((|out_grants[PORT_NEXT]) && !credit_ret_west) begin
            if (credit_west_q == '0) credit_err_d  = 1'b1;
            else                     credit_west_d = credit_west_q - 1'b1;
        end else if (credit_ret_west && !(|out_grants[PORT_NEXT])) begin
            if (credit_west_q == CREDIT_MAX) credit_err_d  = 1'b1;
            else                             credit_west_d = credit_west_q + 1'b1;
        end
    end

    // Credit counters and sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credit_east_q <= CREDIT_MAX;
            credit_west_q <= CREDIT_MAX;
            credit_err_q  <= 1'b0;
        end else begin
            credit_east_q <= credit_east_d;
            credit_west_q <= credit_west_d;
            credit_err_q  <= credit_err_d;
        end
    end

    assign num_free_east = credit_east_q;
    assign num_free_west = credit_west_q;
    assign credit_err    = credit_err_q;

endmodule

// File: doc/plab4_net_router_switch_alloc.md
Name: plab4_net_router_switch_alloc

Overview:
Switch allocator and downstream credit tracker for one ring router. It collects the 3-bit output requests from the router's three input terminal controllers and returns one-hot grants. Each of the three outputs is allocated by its own round-robin arbiter. The block also keeps free-slot counts for the two ring-facing outputs and drives them back to the input controllers, which use them for bubble flow control.

Parameters:
p_num_free_nbits, 2, width of num_free_* outputs
p_credit_init, 2, downstream buffer depth (reset/max credit); must satisfy p_credit_init < 2**p_num_free_nbits

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
reqs_in0  in  3  requests from input 0 (prev side); bit0=out prev, bit1=out term, bit2=out next
reqs_in1  in  3  requests from input 1 (terminal)
reqs_in2  in  3  requests from input 2 (next side)
grants_in0  out  3  one-hot (or zero) grant to input 0, same bit mapping as reqs
grants_in1  out  3  grant to input 1
grants_in2  out  3  grant to input 2
term_out_rdy  in  1  terminal output can accept a flit this cycle
credit_ret_east  in  1  one slot freed in buffer behind output prev
credit_ret_west  in  1  one slot freed in buffer behind output next
num_free_east  out  p_num_free_nbits  credits for output prev
num_free_west  out  p_num_free_nbits  credits for output next
credit_err  out  1  sticky: credit overflow or underflow detected
cur_sd  in  1  current security domain (public label)

Behaviour:
- Async reset (reset==0): all priority pointers = input 0; credit_east = credit_west = p_credit_init; credit_err = 0. Grants are combinational, so they are 0 whenever requests are 0.
- Grants are combinational, 0-cycle latency. A grant implies the flit transfers that cycle.
- Per output o, eligible requesters are inputs i with reqs_in{i}[o]=1, masked as follows:
  - out prev: masked if credit_east==0.
  - out next: masked if credit_west==0.
  - out term: masked if term_out_rdy==0.
- Each output grants the first eligible input starting from ptr[o], wrapping 2->0.
- An input requests at most one output (one-hot reqs), so grants_in{i} is one-hot or zero. Multi-hot reqs: undefined, not checked.
- On rising clk, if output o granted input g: ptr[o] <= (g+1) mod 3. No grant: ptr holds.
- Credit update per counter, same edge:
  - grant only: decrement.
  - return only: increment.
  - grant and return in the same cycle: unchanged.
- Underflow or overflow: counter saturates, credit_err <= 1. Overflow means a return while the counter is at p_credit_init. Underflow cannot occur through grants because of the masking.
- num_free_* equals the counter zero-extended or truncated to p_num_free_nbits; it is a registered value.
- Input controllers request prev/next only when num_free>1. The allocator's own zero-credit mask is a safety net only.
- Reset asserted mid-transfer: state clears immediately. In-flight credits are lost; the environment must reset downstream buffers together with this block.

Optional Feature:
PLAB4_NET_SWITCH_ALLOC_SD_FLUSH_EN
- Defined: a prev_sd register (reset 0) tracks cur_sd. In any cycle where cur_sd != prev_sd, all grants are forced to 0 and all ptr reset to input 0 at the edge. This removes arbitration-history timing leakage across domain switches. Credits are unaffected.
- Undefined: cur_sd is ignored and pointers persist across domain changes.

Decomposition:
- Shared package/header holds:
  - output index constants PORT_PREV=0, PORT_TERM=1, PORT_NEXT=2, matching the route encodings used by the route compute.
  - the 3-bit reqs/grants bit mapping.
- One natural sub-module: plab4_net_rr_arb3. It is a 3-input round-robin arbiter with reqs, grant and a priority pointer register; instantiate it three times.
- Credit counters stay inline.

Test Plan:
- Reset then idle: num_free_east=num_free_west=2, all grants 0, credit_err=0.
- All three inputs request term, term_out_rdy=1, for 3 cycles: grants go to input 0, then 1, then 2 (grants_inN=3'b010 in turn).
- Input 1 requests prev with no credit_ret: num_free_east goes 2->1->0. The third request gets no grant while credit_east==0. credit_ret_east then restores 1 and a grant follows.
- Grant on next and credit_ret_west in the same cycle with credit 1: num_free_west stays 1.
- credit_ret_east while credit_east=2: counter stays 2, credit_err=1, and stays 1 until reset.
- With SD_FLUSH_EN, ptr[term]=2, then toggle cur_sd while inputs 0 and 2 request term: that cycle gives no grants. Next cycle grants input 0.
